// File: rtl/gsu_mem_arbiter_pkg.sv
// Shared definitions for the GSU/SNES memory arbiter: FSM state codes,
// legal access length range and chip select codes.
package gsu_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SNES_ACC = 2'd1,
    ST_GSU_ACC  = 2'd2,
    ST_RECOVER  = 2'd3
  } state_t;

  localparam int ACC_CYCLES_MIN = 2;
  localparam int ACC_CYCLES_MAX = 15;

  localparam logic SEL_ROM = 1'b0;
  localparam logic SEL_RAM = 1'b1;

  function automatic bit acc_cycles_legal(input int n);
    return (n >= ACC_CYCLES_MIN) && (n <= ACC_CYCLES_MAX);
  endfunction

endpackage

// File: rtl/gsu_mem_arbiter_snes_req_capture.sv
// One-deep SNES request slot: hit qualification, pending storage, sticky overflow.
// cur_* shows the pending entry if any, else the live request; take consumes it.
module snes_req_capture
  import gsu_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              snes_req,
  input  logic              snes_we,
  input  logic [ADDR_W-1:0] snes_addr,
  input  logic [7:0]        snes_wdata,
  input  logic              snes_rom_hit,
  input  logic              snes_ram_hit,
  input  logic              take,
  output logic              cur_vld,
  output logic              cur_we,
  output logic              cur_ram,
  output logic [ADDR_W-1:0] cur_addr,
  output logic [7:0]        cur_wdata,
  output logic              snes_ovf
);

  logic              req_hit;
  logic              load;
  logic              pend_vld;
  logic              pend_we;
  logic              pend_ram;
  logic [ADDR_W-1:0] pend_addr;
  logic [7:0]        pend_wdata;

  assign req_hit = snes_req & (snes_rom_hit | snes_ram_hit);
  // A live request is stored if it is not taken directly, or if it arrives
  // exactly as the pending entry is consumed (refill).
  assign load    = req_hit & (take ? pend_vld : !pend_vld);

  assign cur_vld   = pend_vld | req_hit;
  assign cur_we    = pend_vld ? pend_we    : snes_we;
  assign cur_ram   = pend_vld ? pend_ram   : snes_ram_hit;
  assign cur_addr  = pend_vld ? pend_addr  : snes_addr;
  assign cur_wdata = pend_vld ? pend_wdata : snes_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld   <= 1'b0;
      pend_we    <= 1'b0;
      pend_ram   <= 1'b0;
      pend_addr  <= '0;
      pend_wdata <= '0;
      snes_ovf   <= 1'b0;
    end else begin
      pend_vld <= take ? (pend_vld & req_hit) : (pend_vld | req_hit);
      if (load) begin
        pend_we    <= snes_we;
        pend_ram   <= snes_ram_hit;
        pend_addr  <= snes_addr;
        pend_wdata <= snes_wdata;
      end
      if (!take && req_hit && pend_vld)
        snes_ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/gsu_mem_arbiter.sv
// Shares one external memory port between SNES (absolute priority) and GSU.
// Optional ARB_STALL_CNT_EN adds a saturating GSU stall counter with clear.
module gsu_mem_arbiter
  import gsu_mem_arbiter_pkg::*;
#(
  parameter int ACCESS_CYCLES = 4,
  parameter int ADDR_W        = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              snes_req,
  input  logic              snes_we,
  input  logic [ADDR_W-1:0] snes_addr,
  input  logic [7:0]        snes_wdata,
  input  logic              snes_rom_hit,
  input  logic              snes_ram_hit,
  output logic [7:0]        snes_rdata,
  output logic              snes_rdy,
  output logic              snes_ovf,
  input  logic              gsu_valid,
  output logic              gsu_ready,
  input  logic              gsu_we,
  input  logic              gsu_ram,
  input  logic [ADDR_W-1:0] gsu_addr,
  input  logic [7:0]        gsu_wdata,
  output logic [7:0]        gsu_rdata,
  output logic              gsu_ack,
`ifdef ARB_STALL_CNT_EN
  output logic [15:0]       gsu_stall_cnt,
  input  logic              stall_clr,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              mem_oe,
  output logic              mem_we,
  output logic              mem_ram_sel
);

  if (!acc_cycles_legal(ACCESS_CYCLES)) begin : g_bad_access_cycles
    $error("gsu_mem_arbiter: ACCESS_CYCLES out of range 2..15");
  end

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cnt;
  logic              take;
  logic              acc_snes;
  logic              acc_we;
  logic              acc_we_en;

  logic              cur_vld;
  logic              cur_we;
  logic              cur_ram;
  logic [ADDR_W-1:0] cur_addr;
  logic [7:0]        cur_wdata;

  snes_req_capture #(.ADDR_W(ADDR_W)) u_capture (
    .clk          (clk),
    .rst          (rst),
    .snes_req     (snes_req),
    .snes_we      (snes_we),
    .snes_addr    (snes_addr),
    .snes_wdata   (snes_wdata),
    .snes_rom_hit (snes_rom_hit),
    .snes_ram_hit (snes_ram_hit),
    .take         (take),
    .cur_vld      (cur_vld),
    .cur_we       (cur_we),
    .cur_ram      (cur_ram),
    .cur_addr     (cur_addr),
    .cur_wdata    (cur_wdata),
    .snes_ovf     (snes_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cur_vld)        state_nxt = ST_SNES_ACC;
        else if (gsu_valid) state_nxt = ST_GSU_ACC;
      end
      ST_SNES_ACC,
      ST_GSU_ACC:  if (cnt == 4'd0) state_nxt = ST_RECOVER;
      ST_RECOVER:  state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    take      = 1'b0;
    gsu_ready = 1'b0;
    mem_oe    = 1'b0;
    mem_we    = 1'b0;
    snes_rdy  = 1'b0;
    gsu_ack   = 1'b0;
    case (state)
      ST_IDLE: begin
        take      = cur_vld;
        gsu_ready = !cur_vld && gsu_valid;
      end
      ST_SNES_ACC,
      ST_GSU_ACC: begin
        mem_oe = !acc_we;
        mem_we = acc_we_en;
      end
      ST_RECOVER: begin
        snes_rdy = acc_snes;
        gsu_ack  = !acc_snes;
      end
      default: ;
    endcase
  end

  // Counter is preloaded while idle so the strobe lasts exactly ACCESS_CYCLES.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 cnt <= '0;
    else if (state == ST_IDLE) cnt <= CNT_LOAD;
    else if (cnt != 4'd0)    cnt <= cnt - 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_snes    <= 1'b0;
      acc_we      <= 1'b0;
      acc_we_en   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_ram_sel <= SEL_ROM;
    end else if (state == ST_IDLE) begin
      if (cur_vld) begin
        acc_snes    <= 1'b1;
        acc_we      <= cur_we;
        acc_we_en   <= cur_we & cur_ram;  // ROM is read-only for the SNES
        mem_addr    <= cur_addr;
        mem_wdata   <= cur_wdata;
        mem_ram_sel <= cur_ram ? SEL_RAM : SEL_ROM;
      end else if (gsu_valid) begin
        acc_snes    <= 1'b0;
        acc_we      <= gsu_we;
        acc_we_en   <= gsu_we;
        mem_addr    <= gsu_addr;
        mem_wdata   <= gsu_wdata;
        mem_ram_sel <= gsu_ram ? SEL_RAM : SEL_ROM;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snes_rdata <= '0;
      gsu_rdata  <= '0;
    end else if (cnt == 4'd0 && !acc_we) begin
      if (state == ST_SNES_ACC)     snes_rdata <= mem_rdata;
      else if (state == ST_GSU_ACC) gsu_rdata  <= mem_rdata;
    end
  end

`ifdef ARB_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                   gsu_stall_cnt <= '0;
    else if (stall_clr)                                        gsu_stall_cnt <= '0;
    else if (gsu_valid && !gsu_ready && gsu_stall_cnt != 16'hFFFF) gsu_stall_cnt <= gsu_stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_gsu_mem_arbiter.sv
// Directed bench for gsu_mem_arbiter (ACCESS_CYCLES=4); inputs driven 1ns after
// the rising edge, outputs checked 3ns after it.
module tb_gsu_mem_arbiter;
  import gsu_mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        snes_req, snes_we, snes_rom_hit, snes_ram_hit;
  logic [23:0] snes_addr;
  logic [7:0]  snes_wdata, snes_rdata;
  logic        snes_rdy, snes_ovf;
  logic        gsu_valid, gsu_ready, gsu_we, gsu_ram, gsu_ack;
  logic [23:0] gsu_addr;
  logic [7:0]  gsu_wdata, gsu_rdata;
  logic [23:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_oe, mem_we, mem_ram_sel;
`ifdef ARB_STALL_CNT_EN
  logic [15:0] gsu_stall_cnt;
  logic        stall_clr;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gsu_mem_arbiter #(.ACCESS_CYCLES(4), .ADDR_W(24)) dut (
    .clk          (clk),
    .rst          (rst),
    .snes_req     (snes_req),
    .snes_we      (snes_we),
    .snes_addr    (snes_addr),
    .snes_wdata   (snes_wdata),
    .snes_rom_hit (snes_rom_hit),
    .snes_ram_hit (snes_ram_hit),
    .snes_rdata   (snes_rdata),
    .snes_rdy     (snes_rdy),
    .snes_ovf     (snes_ovf),
    .gsu_valid    (gsu_valid),
    .gsu_ready    (gsu_ready),
    .gsu_we       (gsu_we),
    .gsu_ram      (gsu_ram),
    .gsu_addr     (gsu_addr),
    .gsu_wdata    (gsu_wdata),
    .gsu_rdata    (gsu_rdata),
    .gsu_ack      (gsu_ack),
`ifdef ARB_STALL_CNT_EN
    .gsu_stall_cnt(gsu_stall_cnt),
    .stall_clr    (stall_clr),
`endif
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_oe       (mem_oe),
    .mem_we       (mem_we),
    .mem_ram_sel  (mem_ram_sel)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic snes_drive(input logic we, input logic rom, input logic ram,
                            input logic [23:0] a, input logic [7:0] d);
    snes_req = 1'b1; snes_we = we; snes_rom_hit = rom; snes_ram_hit = ram;
    snes_addr = a; snes_wdata = d;
  endtask

  // Called in the request cycle; walks strobe cycles 1..4 and the RECOVER cycle.
  // inject issues SNES reads at strobe cycles 1..3 (0x400, 0x500, 0x600).
  task automatic run_access(input string tag, input logic snes_side,
                            input logic exp_oe, input logic exp_we, input logic exp_sel,
                            input logic [23:0] exp_addr, input logic [7:0] exp_wd,
                            input bit inject);
    for (int i = 1; i <= 4; i++) begin
      step();
      snes_req = 1'b0;
      if (!snes_side) gsu_valid = 1'b0;
      if (inject && i <= 3) snes_drive(1'b0, 1'b1, 1'b0, 24'h000300 + 24'(i) * 24'h100, 8'h00);
      settle();
      chk({tag, "_oe"},   {31'd0, mem_oe},      {31'd0, exp_oe});
      chk({tag, "_we"},   {31'd0, mem_we},      {31'd0, exp_we});
      chk({tag, "_sel"},  {31'd0, mem_ram_sel}, {31'd0, exp_sel});
      chk({tag, "_addr"}, {8'd0, mem_addr},     {8'd0, exp_addr});
      if (exp_we) chk({tag, "_wd"}, {24'd0, mem_wdata}, {24'd0, exp_wd});
      chk({tag, "_done_early"}, {30'd0, snes_rdy, gsu_ack}, 32'd0);
      chk({tag, "_gsu_ready_busy"}, {31'd0, gsu_ready}, 32'd0);
      if (inject && i == 3) chk({tag, "_ovf_set"}, {31'd0, snes_ovf}, 32'd1);
    end
    step();
    snes_req = 1'b0;
    settle();
    chk({tag, "_rec_strobes"}, {30'd0, mem_oe, mem_we}, 32'd0);
    chk({tag, "_rdy"}, {31'd0, snes_rdy}, {31'd0, snes_side});
    chk({tag, "_ack"}, {31'd0, gsu_ack},  {31'd0, !snes_side});
  endtask

  initial begin
    rst = 1'b1;
    snes_req = 0; snes_we = 0; snes_rom_hit = 0; snes_ram_hit = 0;
    snes_addr = '0; snes_wdata = '0;
    gsu_valid = 0; gsu_we = 0; gsu_ram = 0; gsu_addr = '0; gsu_wdata = '0;
    mem_rdata = 8'h00;
`ifdef ARB_STALL_CNT_EN
    stall_clr = 1'b0;
`endif
    step(); step();
    settle();
    chk("rst_strobes", {29'd0, mem_oe, mem_we, mem_ram_sel}, 32'd0);
    chk("rst_addr", {8'd0, mem_addr}, 32'd0);
    chk("rst_flags", {28'd0, snes_rdy, gsu_ack, gsu_ready, snes_ovf}, 32'd0);
    chk("rst_rdata", {16'd0, snes_rdata, gsu_rdata}, 32'd0);
    step();
    rst = 1'b0;

    // 1: SNES ROM read
    step();
    snes_drive(1'b0, 1'b1, 1'b0, 24'h012345, 8'h00);
    mem_rdata = 8'hA5;
    settle();
    chk("t1_idle_oe", {31'd0, mem_oe}, 32'd0);
    run_access("t1", 1'b1, 1'b1, 1'b0, SEL_ROM, 24'h012345, 8'h00, 1'b0);
    chk("t1_rdata", {24'd0, snes_rdata}, 32'h0000_00A5);
    step();
    settle();
    chk("t1_rdy_pulse", {31'd0, snes_rdy}, 32'd0);
    chk("t1_state_idle", {30'd0, dut.state}, 32'd0);

    // 2: simultaneous SNES and GSU, SNES wins
    snes_drive(1'b0, 1'b1, 1'b0, 24'h000100, 8'h00);
    gsu_valid = 1'b1; gsu_we = 1'b0; gsu_ram = 1'b1; gsu_addr = 24'h000200;
    mem_rdata = 8'h11;
    settle();
    chk("t2_gsu_blocked", {31'd0, gsu_ready}, 32'd0);
    run_access("t2s", 1'b1, 1'b1, 1'b0, SEL_ROM, 24'h000100, 8'h00, 1'b0);
    step();
    mem_rdata = 8'h3C;
    settle();
    chk("t2_gsu_ready", {31'd0, gsu_ready}, 32'd1);
    run_access("t2g", 1'b0, 1'b1, 1'b0, SEL_RAM, 24'h000200, 8'h00, 1'b0);
    chk("t2_gsu_rdata", {24'd0, gsu_rdata}, 32'h0000_003C);
    chk("t2_snes_rdata_kept", {24'd0, snes_rdata}, 32'h0000_0011);

    // 3: three SNES requests during a GSU write
    step();
    gsu_valid = 1'b1; gsu_we = 1'b1; gsu_ram = 1'b1; gsu_addr = 24'h000300; gsu_wdata = 8'h77;
    mem_rdata = 8'h5E;
    settle();
    chk("t3_gsu_ready", {31'd0, gsu_ready}, 32'd1);
    run_access("t3g", 1'b0, 1'b0, 1'b1, SEL_RAM, 24'h000300, 8'h77, 1'b1);
    step();
    settle();
    chk("t3_take_idle", {30'd0, mem_oe, mem_we}, 32'd0);
    run_access("t3s", 1'b1, 1'b1, 1'b0, SEL_ROM, 24'h000400, 8'h00, 1'b0);
    chk("t3_snes_rdata", {24'd0, snes_rdata}, 32'h0000_005E);
    chk("t3_gsu_rdata_kept", {24'd0, gsu_rdata}, 32'h0000_003C);
    for (int i = 0; i < 3; i++) begin
      step();
      settle();
      chk("t3_no_dropped_access", {29'd0, mem_oe, mem_we, snes_rdy}, 32'd0);
    end
    chk("t3_ovf_sticky", {31'd0, snes_ovf}, 32'd1);

    // 4: SNES RAM write, then the same write with ROM hit only
    step();
    snes_drive(1'b1, 1'b0, 1'b1, 24'hC00010, 8'h5A);
    settle();
    run_access("t4ram", 1'b1, 1'b0, 1'b1, SEL_RAM, 24'hC00010, 8'h5A, 1'b0);
    step();
    snes_drive(1'b1, 1'b1, 1'b0, 24'hC00010, 8'h5A);
    settle();
    run_access("t4rom", 1'b1, 1'b0, 1'b0, SEL_ROM, 24'hC00010, 8'h5A, 1'b0);
    chk("t4_rdata_kept", {24'd0, snes_rdata}, 32'h0000_005E);

    // 5: reset during GSU read, then SNES request with no hit
    step();
    gsu_valid = 1'b1; gsu_we = 1'b0; gsu_ram = 1'b0; gsu_addr = 24'h00ABCD;
    step();
    gsu_valid = 1'b0;
    settle();
    chk("t5_gsu_oe", {31'd0, mem_oe}, 32'd1);
    step();
    rst = 1'b1;
    #1;
    chk("t5_rst_oe_drop", {31'd0, mem_oe}, 32'd0);
    chk("t5_rst_state", {30'd0, dut.state}, 32'd0);
    chk("t5_rst_ovf_clr", {31'd0, snes_ovf}, 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      settle();
      chk("t5_no_ack", {29'd0, gsu_ack, mem_oe, mem_we}, 32'd0);
    end
    step();
    snes_drive(1'b0, 1'b0, 1'b0, 24'h001234, 8'h00);
    step();
    snes_req = 1'b0;
    gsu_valid = 1'b1; gsu_addr = 24'h000055;
    settle();
    chk("t5_nohit_no_pending", {31'd0, gsu_ready}, 32'd1);
    chk("t5_nohit_no_strobe", {30'd0, mem_oe, snes_rdy}, 32'd0);
    run_access("t5g", 1'b0, 1'b1, 1'b0, SEL_ROM, 24'h000055, 8'h00, 1'b0);
    chk("t5_nohit_no_ovf", {31'd0, snes_ovf}, 32'd0);

`ifdef ARB_STALL_CNT_EN
    // 6: stall counter
    step();
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    snes_drive(1'b0, 1'b1, 1'b0, 24'h000010, 8'h00);
    step();
    snes_drive(1'b0, 1'b1, 1'b0, 24'h000020, 8'h00);
    step();
    snes_req = 1'b0;
    gsu_valid = 1'b1; gsu_we = 1'b0; gsu_addr = 24'h000030;
    for (int i = 0; i < 10; i++) step();
    settle();
    chk("t6_ready_after_block", {31'd0, gsu_ready}, 32'd1);
    chk("t6_cnt10", {16'd0, gsu_stall_cnt}, 32'd10);
    step();
    gsu_valid = 1'b0;
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    settle();
    chk("t6_clr", {16'd0, gsu_stall_cnt}, 32'd0);
    for (int i = 0; i < 6; i++) step();
    snes_drive(1'b0, 1'b1, 1'b0, 24'h000040, 8'h00);
    gsu_valid = 1'b1;
    for (int i = 0; i < 70000; i++) step();
    settle();
    chk("t6_sat", {16'd0, gsu_stall_cnt}, 32'h0000_FFFF);
    step();
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    settle();
    chk("t6_clr_wins", {16'd0, gsu_stall_cnt}, 32'd0);
    snes_req = 1'b0;
    gsu_valid = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
